rt_cmd_queue: RTL and testbench

Real-time command queue feeding the pulse-burst sequencer. It accepts complete burst commands from the host/control side, buffers them in order, and presents one command at a time on the sequencer's `MEM_*` bus with a single-cycle `WR_DATA` strobe. Each new command is released only after the sequencer raises `REQ_COMMAND`, meaning the previous command has started. Commands whose start time is already too close or in the past are discarded and counted.

---
 rtl/rt_cmd_pkg.sv | 25 ++
 rtl/rt_cmd_ram.sv | 24 ++
 rtl/rt_cmd_queue.sv | 132 +++++++++++++
 tb/tb_rt_cmd_queue.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_cmd_pkg.sv
// Shared types for the real-time command queue: burst command layout and
// read-side sequencing states.
package rt_cmd_pkg;

   typedef struct packed {
      logic [47:0] freq;
      logic [47:0] dfreq;
      logic [31:0] drate;
      logic [63:0] time_start;
      logic [15:0] n_impuls;
      logic [1:0]  type_impulse;
      logic [31:0] ti;
      logic [31:0] tp;
      logic [31:0] tb1;
      logic [31:0] tb2;
   } cmd_t;

   localparam int unsigned CMD_W = 338;

   // Idle downstream bus: start time parked at the far future.
   localparam cmd_t CMD_RST = '{time_start: '1, default: '0};

   typedef enum logic [1:0] {IDLE, READ, CHECK, LOAD} rd_state_t;

endpackage

// File: rtl/rt_cmd_ram.sv
// Simple dual-port command store: one write port, one registered read port.
module rt_cmd_ram
   import rt_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [CMD_W-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [CMD_W-1:0] rdata_o
);

   logic [CMD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/rt_cmd_queue.sv
// In-order burst command queue; releases one command per sequencer request
// and discards commands whose start time has come too close.
module rt_cmd_queue
   import rt_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned LEAD  = 64
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [CMD_W-1:0]       IN_CMD,
   input  logic                   FLUSH,
   input  logic [63:0]            TIME,
   input  logic                   TIME_VALID,
   input  logic                   REQ_COMMAND,
   output logic                   WR_DATA,
   output logic [47:0]            MEM_DDS_freq,
   output logic [47:0]            MEM_DDS_delta_freq,
   output logic [31:0]            MEM_DDS_delta_rate,
   output logic [63:0]            MEM_TIME_START,
   output logic [15:0]            MEM_N_impuls,
   output logic [1:0]             MEM_TYPE_impulse,
   output logic [31:0]            MEM_Interval_Ti,
   output logic [31:0]            MEM_Interval_Tp,
   output logic [31:0]            MEM_Tblank1,
   output logic [31:0]            MEM_Tblank2,
   output logic [$clog2(DEPTH):0] COUNT,
   output logic [15:0]            LATE_CNT,
   output logic                   LOADED
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [63:0] LEAD64   = 64'(LEAD);

   rd_state_t        state_q;
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q, count_d;
   logic             req_prev_q, loaded_q, wr_data_q;
   logic [15:0]      late_q;
   cmd_t             mem_q, head;
   logic [CMD_W-1:0] ram_rdata;
   logic             push, pop, late, req_rise;

   rt_cmd_ram #(.DEPTH(DEPTH)) u_ram (
      .clk_i   (CLK),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (IN_CMD),
      .re_i    (state_q == READ),
      .raddr_i (rptr_q),
      .rdata_o (ram_rdata)
   );

   assign head     = cmd_t'(ram_rdata);
   assign IN_READY = (count_q != FULL_CNT);
   assign push     = IN_VALID && IN_READY && !FLUSH;
   assign late     = (head.time_start <= TIME + LEAD64);
   // Both outcomes of CHECK consume the head; FLUSH abandons it instead.
   assign pop      = (state_q == CHECK) && !FLUSH;
   assign req_rise = REQ_COMMAND && !req_prev_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         req_prev_q <= 1'b0;
         loaded_q   <= 1'b0;
         wr_data_q  <= 1'b0;
         late_q     <= '0;
         mem_q      <= CMD_RST;
      end else begin
         req_prev_q <= REQ_COMMAND;
         wr_data_q  <= 1'b0;
         if (req_rise && loaded_q) loaded_q <= 1'b0;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;

         case (state_q)
            IDLE: if (!FLUSH && !loaded_q && count_q != '0 && TIME_VALID) state_q <= READ;
            READ: state_q <= FLUSH ? IDLE : CHECK;
            CHECK: begin
               state_q <= IDLE;
               if (!FLUSH) begin
                  if (late) begin
                     if (late_q != '1) late_q <= late_q + 16'd1;
                  end else begin
                     mem_q     <= head;
                     wr_data_q <= 1'b1;
                     loaded_q  <= 1'b1;
                     state_q   <= LOAD;
                  end
               end
            end
            LOAD:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase

         if (FLUSH) begin
            wptr_q  <= rptr_q;
            count_q <= '0;
         end
      end
   end

   assign WR_DATA            = wr_data_q;
   assign LOADED             = loaded_q;
   assign COUNT              = count_q;
   assign LATE_CNT           = late_q;
   assign MEM_DDS_freq       = mem_q.freq;
   assign MEM_DDS_delta_freq = mem_q.dfreq;
   assign MEM_DDS_delta_rate = mem_q.drate;
   assign MEM_TIME_START     = mem_q.time_start;
   assign MEM_N_impuls       = mem_q.n_impuls;
   assign MEM_TYPE_impulse   = mem_q.type_impulse;
   assign MEM_Interval_Ti    = mem_q.ti;
   assign MEM_Interval_Tp    = mem_q.tp;
   assign MEM_Tblank1        = mem_q.tb1;
   assign MEM_Tblank2        = mem_q.tb2;

endmodule

// File: tb/tb_rt_cmd_queue.sv
// Bench for rt_cmd_queue: directed latency/late/full/flush/reset steps, then
// random traffic checked against a FIFO reference model.
module tb_rt_cmd_queue;
   import rt_cmd_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LEAD  = 64;

   logic        CLK = 1'b0;
   logic        RESET_N, IN_VALID, IN_READY, FLUSH, TIME_VALID, REQ_COMMAND, WR_DATA, LOADED;
   cmd_t        IN_CMD;
   logic [63:0] TIME;
   logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq;
   logic [31:0] MEM_DDS_delta_rate, MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
   logic [63:0] MEM_TIME_START;
   logic [15:0] MEM_N_impuls, LATE_CNT;
   logic [1:0]  MEM_TYPE_impulse;
   logic [4:0]  COUNT;

   int   checks = 0;
   int   errors = 0;
   cmd_t mq[$];
   bit   model_loaded;
   int   late_exp;

   rt_cmd_queue #(.DEPTH(DEPTH), .LEAD(LEAD)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_CMD(IN_CMD), .FLUSH(FLUSH), .TIME(TIME), .TIME_VALID(TIME_VALID),
      .REQ_COMMAND(REQ_COMMAND), .WR_DATA(WR_DATA),
      .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
      .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
      .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
      .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
      .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2),
      .COUNT(COUNT), .LATE_CNT(LATE_CNT), .LOADED(LOADED)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [337:0] obs, input logic [337:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic cmd_t mem_obs();
      cmd_t c;
      c.freq = MEM_DDS_freq;          c.dfreq = MEM_DDS_delta_freq;
      c.drate = MEM_DDS_delta_rate;   c.time_start = MEM_TIME_START;
      c.n_impuls = MEM_N_impuls;      c.type_impulse = MEM_TYPE_impulse;
      c.ti = MEM_Interval_Ti;         c.tp = MEM_Interval_Tp;
      c.tb1 = MEM_Tblank1;            c.tb2 = MEM_Tblank2;
      return c;
   endfunction

   function automatic cmd_t mk(input logic [63:0] ts);
      cmd_t c;
      c.freq = {16'($urandom()), $urandom()};
      c.dfreq = {16'($urandom()), $urandom()};
      c.drate = $urandom();
      c.time_start = ts;
      c.n_impuls = 16'($urandom());
      c.type_impulse = 2'($urandom());
      c.ti = $urandom();  c.tp = $urandom();
      c.tb1 = $urandom(); c.tb2 = $urandom();
      return c;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
      TIME = TIME + 64'd1;
   endtask

   task automatic wr(input cmd_t c);
      IN_CMD = c;
      IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
   endtask

   // lat counts clock edges from the one that samples the request/write (=1).
   task automatic run_window(input int cycles, input bit do_req, input bit drop_valid,
                             output int lat, output int pulses, output cmd_t seen,
                             output logic loaded_at, output logic [4:0] count_at);
      lat = 0; pulses = 0; seen = '0; loaded_at = 1'b0; count_at = '0;
      if (do_req) REQ_COMMAND = 1'b1;
      for (int k = 1; k <= cycles; k++) begin
         step();
         if (k == 1) begin
            REQ_COMMAND = 1'b0;
            if (drop_valid) IN_VALID = 1'b0;
         end
         if (WR_DATA === 1'b1) begin
            pulses++;
            if (lat == 0) begin
               lat = k; seen = mem_obs(); loaded_at = LOADED; count_at = COUNT;
            end
         end
      end
   endtask

   task automatic observe();
      cmd_t e;
      if (WR_DATA === 1'b1) begin
         chk("rnd_load_while_loaded", model_loaded, 1'b0);
         while (mq.size() > 0 && mq[0].time_start <= TIME + 64'(LEAD)) begin
            void'(mq.pop_front());
            late_exp++;
         end
         e = '0;
         if (mq.size() > 0) e = mq.pop_front();
         chk("rnd_mem", mem_obs(), e);
         chk("rnd_late_cnt", LATE_CNT, 16'(late_exp));
         model_loaded = 1'b1;
      end
   endtask

   initial begin
      cmd_t a, b, c, d, l, e, x, y, g, h, m, z, nc, seen;
      cmd_t f[DEPTH];
      int lat, pulses;
      logic ld;
      logic [4:0] cnt;
      logic [63:0] t0;
      bit acc, found;

      RESET_N = 1'b0; IN_VALID = 1'b0; IN_CMD = '0; FLUSH = 1'b0;
      TIME = 64'd1000; TIME_VALID = 1'b0; REQ_COMMAND = 1'b0;
      step(); step();
      RESET_N = 1'b1;
      step();
      chk("rst_wr_data", WR_DATA, 1'b0);
      chk("rst_in_ready", IN_READY, 1'b1);
      chk("rst_count", COUNT, 0);
      chk("rst_late_cnt", LATE_CNT, 0);
      chk("rst_loaded", LOADED, 1'b0);
      chk("rst_mem", mem_obs(), CMD_RST);

      // single command into an empty queue
      TIME_VALID = 1'b1;
      a = mk(TIME + 64'd1000);
      IN_CMD = a; IN_VALID = 1'b1;
      run_window(20, 1'b0, 1'b1, lat, pulses, seen, ld, cnt);
      chk("first_latency", lat, 4);
      chk("first_pulses", pulses, 1);
      chk("first_mem", seen, a);
      chk("first_loaded", ld, 1'b1);
      chk("first_count", cnt, 0);

      // FIFO order, one load per request edge
      b = mk(TIME + 64'd2000); c = mk(TIME + 64'd2000); d = mk(TIME + 64'd2000);
      wr(b); wr(c); wr(d);
      step();
      chk("three_count", COUNT, 3);
      chk("three_held_loaded", LOADED, 1'b1);
      run_window(50, 1'b1, 1'b0, lat, pulses, seen, ld, cnt);
      chk("req1_latency", lat, 4);
      chk("req1_pulses", pulses, 1);
      chk("req1_mem", seen, b);
      run_window(50, 1'b1, 1'b0, lat, pulses, seen, ld, cnt);
      chk("req2_latency", lat, 4);
      chk("req2_pulses", pulses, 1);
      chk("req2_mem", seen, c);
      chk("req2_count", COUNT, 1);

      // late command discarded, next valid one loads
      l = mk(TIME + 64'd10); e = mk(TIME + 64'd1000);
      wr(l); wr(e);
      run_window(50, 1'b1, 1'b0, lat, pulses, seen, ld, cnt);
      chk("late_pre_mem", seen, d);
      run_window(50, 1'b1, 1'b0, lat, pulses, seen, ld, cnt);
      chk("late_pulses", pulses, 1);
      chk("late_latency", lat, 7);
      chk("late_mem", seen, e);
      chk("late_cnt1", LATE_CNT, 1);

      // start time exactly TIME+LEAD at check is late; one tick more is not
      t0 = TIME + 64'd2;
      x = mk(t0 + 64'd3 + 64'(LEAD));
      y = mk(t0 + 64'd6 + 64'(LEAD) + 64'd1);
      wr(x); wr(y);
      run_window(50, 1'b1, 1'b0, lat, pulses, seen, ld, cnt);
      chk("bound_latency", lat, 7);
      chk("bound_mem", seen, y);
      chk("bound_late_cnt", LATE_CNT, 2);

      // fill to DEPTH, overflow write ignored, refill after a pop
      for (int i = 0; i < DEPTH; i++) begin
         f[i] = mk(TIME + 64'd5000);
         wr(f[i]);
      end
      chk("full_count", COUNT, DEPTH);
      chk("full_in_ready", IN_READY, 1'b0);
      g = mk(TIME + 64'd5000);
      wr(g);
      chk("full_overflow_count", COUNT, DEPTH);
      h = mk(TIME + 64'd5000);
      IN_CMD = h; IN_VALID = 1'b1;
      run_window(30, 1'b1, 1'b0, lat, pulses, seen, ld, cnt);
      IN_VALID = 1'b0;
      chk("full_pop_mem", seen, f[0]);
      chk("full_pop_latency", lat, 4);
      chk("full_refill_count", COUNT, DEPTH);
      chk("full_refill_ready", IN_READY, 1'b0);

      // flush while a head is being checked
      FLUSH = 1'b1; step(); FLUSH = 1'b0;
      chk("flush_idle_count", COUNT, 0);
      for (int i = 0; i < 5; i++) wr(mk(TIME + 64'd5000));
      chk("flush_five_count", COUNT, 5);
      REQ_COMMAND = 1'b1; step(); REQ_COMMAND = 1'b0;
      step(); step();
      FLUSH = 1'b1; IN_CMD = mk(TIME + 64'd5000); IN_VALID = 1'b1;
      step();
      FLUSH = 1'b0; IN_VALID = 1'b0;
      chk("flush_check_count", COUNT, 0);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (WR_DATA === 1'b1) pulses++;
         step();
      end
      chk("flush_no_load", pulses, 0);
      chk("flush_mem_kept", mem_obs(), f[0]);
      chk("flush_loaded", LOADED, 1'b0);
      m = mk(TIME + 64'd1000);
      IN_CMD = m; IN_VALID = 1'b1;
      run_window(20, 1'b0, 1'b1, lat, pulses, seen, ld, cnt);
      chk("post_flush_latency", lat, 4);
      chk("post_flush_mem", seen, m);

      // random traffic against the FIFO model
      model_loaded = 1'b1;
      late_exp = 2;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         IN_VALID = ($urandom_range(0, 9) < 4);
         if ($urandom_range(0, 3) == 0) nc = mk(TIME + 64'($urandom_range(0, LEAD - 20)));
         else nc = mk(TIME + 64'd5000 + 64'($urandom_range(0, 1000)));
         IN_CMD = nc;
         TIME_VALID = ($urandom_range(0, 9) != 0);
         if (REQ_COMMAND) REQ_COMMAND = 1'b0;
         else if ($urandom_range(0, 14) == 0) begin
            REQ_COMMAND = 1'b1;
            model_loaded = 1'b0;
         end
         acc = IN_VALID && IN_READY;
         step();
         if (acc) mq.push_back(nc);
         observe();
      end
      IN_VALID = 1'b0; REQ_COMMAND = 1'b0; TIME_VALID = 1'b1;
      for (int k = 0; k < 80; k++) begin
         step();
         observe();
      end
      if (!model_loaded)
         while (mq.size() > 0 && mq[0].time_start <= TIME + 64'(LEAD)) begin
            void'(mq.pop_front());
            late_exp++;
         end
      chk("rnd_final_count", COUNT, mq.size());
      chk("rnd_final_late", LATE_CNT, 16'(late_exp));
      chk("rnd_final_loaded", LOADED, model_loaded);

      // asynchronous reset in the middle of a load pulse
      FLUSH = 1'b1; step(); FLUSH = 1'b0;
      for (int k = 0; k < 4; k++) step();
      REQ_COMMAND = 1'b1; step(); REQ_COMMAND = 1'b0;
      for (int k = 0; k < 5; k++) step();
      z = mk(TIME + 64'd1000);
      IN_CMD = z; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (WR_DATA === 1'b1) found = 1'b1;
      end
      chk("arst_load_seen", found, 1'b1);
      chk("arst_pre_mem", mem_obs(), z);
      #2 RESET_N = 1'b0;
      #1;
      chk("arst_wr_data", WR_DATA, 1'b0);
      chk("arst_in_ready", IN_READY, 1'b1);
      chk("arst_count", COUNT, 0);
      chk("arst_late_cnt", LATE_CNT, 0);
      chk("arst_loaded", LOADED, 1'b0);
      chk("arst_mem", mem_obs(), CMD_RST);
      step(); step();
      RESET_N = 1'b1;
      step(); step();
      chk("arst_release_count", COUNT, 0);
      chk("arst_release_wr", WR_DATA, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
